// File: rtl/ex_pkg.sv
// ex_pkg: shared types, widths and the forwarding mux for the EX operand stage
package ex_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_t;
  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_t;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] reg_v,
                                              input logic [XLEN-1:0] ex_mem, input logic [XLEN-1:0] mem_wb);
    return sel == FWD_EX_MEM ? ex_mem : sel == FWD_MEM_WB ? mem_wb : reg_v;
  endfunction
endpackage

// File: rtl/ex_operand_stage_mul_iter.sv
// mul_iter: 32-step shift-add multiplier, one multiplier bit per cycle, low word product
module mul_iter
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  logic [XLEN-1:0] mcand, mplier, acc;
  logic [4:0] cnt;
  logic run;
  assign busy = run;
  assign done = run && &cnt;
  assign product = acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (kill) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 5'd1;
      run <= ~&cnt;
    end
  end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: forwarding muxes, ALU and EX/MEM register; EX_MUL_EN adds a stalling iterative MUL
// Without EX_MUL_EN, MUL yields 0 in one cycle and stall is tied low.
module ex_operand_stage
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_result_ex_mem,
  input  logic [XLEN-1:0] wb_data_mem_wb,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [3:0]      op,
  input  logic            valid_in,
  input  logic [4:0]      ard_in,
  input  logic            regwrite_in,
  input  logic            flush,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      ard_out,
  output logic            regwrite_out,
  output logic            valid_out,
  output logic            stall
);
  logic [XLEN-1:0] fwd_a, fwd_b, opb, alu_y, product;
  logic [4:0] m_ard;
  logic m_rw, done_sel;
  assign fwd_a = fwd_mux(forward_a, rs1_data, alu_result_ex_mem, wb_data_mem_wb);
  assign fwd_b = fwd_mux(forward_b, rs2_data, alu_result_ex_mem, wb_data_mem_wb);
  assign opb = alu_src ? imm : fwd_b;
  always_comb begin
    alu_y = '0;
    case (alu_op_t'(op))
      OP_ADD:  alu_y = fwd_a + opb;
      OP_SUB:  alu_y = fwd_a - opb;
      OP_AND:  alu_y = fwd_a & opb;
      OP_OR:   alu_y = fwd_a | opb;
      OP_XOR:  alu_y = fwd_a ^ opb;
      OP_SLL:  alu_y = fwd_a << opb[4:0];
      OP_SRL:  alu_y = fwd_a >> opb[4:0];
      OP_SRA:  alu_y = $signed(fwd_a) >>> opb[4:0];
      OP_SLT:  alu_y = {31'b0, $signed(fwd_a) < $signed(opb)};
      OP_SLTU: alu_y = {31'b0, fwd_a < opb};
      default: alu_y = '0;
    endcase
  end
`ifdef EX_MUL_EN
  mul_state_t state, state_nxt;
  logic mul_req, mul_busy, mul_done;
  assign mul_req = state == IDLE && valid_in && op == OP_MUL;
  assign stall = mul_req || mul_busy;
  assign done_sel = state == MUL_DONE;
  always_comb begin
    state_nxt = flush ? IDLE :
                mul_req ? MUL_BUSY :
                (state == MUL_BUSY && mul_done) ? MUL_DONE :
                done_sel ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_ard <= '0;
      m_rw <= 1'b0;
    end else begin
      state <= state_nxt;
      m_ard <= (mul_req && !flush) ? ard_in : m_ard;
      m_rw <= (mul_req && !flush) ? regwrite_in : m_rw;
    end
  end
  mul_iter u_mul (
    .clk(clk),
    .rst(rst),
    .kill(flush),
    .start(mul_req && !flush),
    .a(fwd_a),
    .b(fwd_b),
    .busy(mul_busy),
    .done(mul_done),
    .product(product)
  );
`else
  assign stall = 1'b0;
  assign done_sel = 1'b0;
  assign product = '0;
  assign m_ard = '0;
  assign m_rw = 1'b0;
`endif
  // MUL_DONE writes the product regardless of the (held) upstream instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      ard_out <= '0;
      regwrite_out <= 1'b0;
      valid_out <= 1'b0;
    end else if (flush || stall || (!valid_in && !done_sel)) begin
      regwrite_out <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      alu_result_out <= done_sel ? product : alu_y;
      store_data_out <= done_sel ? '0 : fwd_b;
      ard_out <= done_sel ? m_ard : ard_in;
      regwrite_out <= done_sel ? m_rw : regwrite_in;
      valid_out <= 1'b1;
    end
  end
endmodule
